lsu_mem_seq: RTL and testbench
==============================

Name: lsu_mem_seq

Overview:
- Load/store sequencer between the CPU memory stage and the single-ported synchronous data memory.
- Accepts one load or store at a time and issues one or two word-aligned memory accesses; two are needed when the access crosses a word boundary.
- Assembles and extends load data (LB/LH/LW/LBU/LHU), generates byte strobes for SB/SH/SW, and returns a one-cycle response. The pipeline stalls on req_ready=0.

Parameters:
- ADDR_W, 32, byte address width
- ALLOW_MISALIGNED, 1, 1 = split boundary-crossing accesses in two; 0 = flag them as errors

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (load 000/001/010/100/101; store 000/001/010)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- req_rd  in  5  destination register index
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_rd  out  5  echoed req_rd for loads; 0 for stores and errors
- rsp_err  out  1  illegal funct3, or misaligned with ALLOW_MISALIGNED=0
- mem_en  out  1  memory access this cycle
- mem_we  out  4  byte write strobes; 0000 = read
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  read data, valid the cycle after a read with mem_en=1

Behaviour:
- Memory is little-endian. Size is 1, 2 or 4 bytes, from funct3[1:0].
- split = (addr[1:0] + size) > 4. Access 0 uses word addr&~3; access 1 uses (addr&~3)+4, wrapping modulo 2^ADDR_W.
- All outputs are registered. Reset values: req_ready=1; every other output 0; state IDLE.
- Reset asserted mid-operation abandons the operation. mem_en drops immediately (asynchronously). No response is produced.
- State IDLE:
  - Accept on the rising edge with req_valid & req_ready. Latch all req_* fields.
  - Illegal funct3 (load 011/110/111, store 1xx/011), or split with ALLOW_MISALIGNED=0: go to RSP with rsp_err=1. No memory access.
  - Otherwise drive access 0 on the mem_* outputs and go to A0.
- State A0 (mem_en=1, access 0):
  - Store, not split -> RSP.
  - Store, split -> A1.
  - Load, not split -> W0.
  - Load, split -> A1.
- State A1 (mem_en=1, access 1): on a load, capture mem_rdata as word 0 at the end of the cycle. Load -> W1; store -> RSP.
- State W0 (mem_en=0): capture word 0 and extract -> RSP.
- State W1 (mem_en=0): capture word 1 and assemble the bytes {w1,w0} starting at offset addr[1:0] -> RSP.
- State RSP: rsp_valid=1 for exactly one cycle with rdata/rd/err -> IDLE. rsp has no backpressure.
- Extension rules:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes all 32 bits unchanged.
- Store lane rules:
  - Bytes are placed at lanes addr[1:0]..addr[1:0]+size-1.
  - In access 0, strobes cover lanes >= addr[1:0]. Access 1 carries the remaining bytes starting at lane 0.
  - Unstrobed lanes of mem_wdata are 0.
- Latency, counted from the accept edge:
  - Aligned load: rsp_valid in the 3rd cycle.
  - Split load: rsp_valid in the 4th cycle.
  - Aligned store: rsp_valid in the 2nd cycle.
  - Split store: rsp_valid in the 3rd cycle.
  - Error: rsp_valid in the 1st cycle.
- Throughput: req_ready is high in IDLE only, so the next request can be accepted on the edge at the end of the RSP cycle's successor (IDLE). No overlapping operations.
- req_valid is ignored while req_ready=0. mem_rdata is ignored in every state except A1 and W0/W1.

Test Plan:
- Memory word0=0x6F409348, word1=0xAABBCCDD.
  - LHU @0 -> rsp_rdata=0x00009348, rsp_rd echoed, rsp_valid in 3rd cycle after accept.
  - LH @0 -> 0xFFFF9348. LH @2 -> 0x00006F40.
  - LB @1 -> 0xFFFFFF93. LBU @1 -> 0x00000093.
- Misaligned LW @1 (ALLOW_MISALIGNED=1) -> two reads, at 0x0 then 0x4, in consecutive cycles; rsp_rdata=0xDD6F4093 in 4th cycle. LHU @3 -> 0x0000DD6F.
- SH @3, wdata 0x00001234:
  - Cycle 1: mem_addr 0x0, mem_we=1000, mem_wdata=0x34000000.
  - Cycle 2: mem_addr 0x4, mem_we=0001, mem_wdata=0x00000012.
  - Cycle 3: rsp_valid=1, rsp_rd=0.
- SB @2, wdata 0xFFFFFFA5 -> single write: mem_we=0100, mem_wdata=0x00A50000.
- Load funct3=011 -> no mem_en ever; rsp_err=1, rsp_rdata=0 in 1st cycle. With ALLOW_MISALIGNED=0, LW @1 -> same error response.
- Assert rst=0 during A1 of a split load -> mem_en=0 immediately, req_ready=1, no rsp_valid. A subsequent LHU @0 completes correctly.

Source files
------------

// File: rtl/lsu_mem_seq.sv
// Load/store sequencer between the CPU memory stage and a single-ported synchronous
// data memory; boundary-crossing accesses are split into two word accesses.
module lsu_mem_seq #(
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A0   = 3'd1,
        S_A1   = 3'd2,
        S_W0   = 3'd3,
        S_W1   = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 32'h0000_00FF;
            2'b01:   size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] strb_base(input logic [1:0] sz);
        case (sz)
            2'b00:   strb_base = 4'b0001;
            2'b01:   strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
        crosses = ({1'b0, off} + size_bytes(sz)) > 3'd4;
    endfunction

    function automatic logic legal_op(input logic we, input logic [2:0] f3);
        if (we) begin
            legal_op = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_op = 1'b1;
                default:                                legal_op = 1'b0;
            endcase
        end
    endfunction

    // Store bytes placed over a two-word window: low word is access 0, high word access 1.
    function automatic logic [63:0] place_data(input logic [31:0] wdata, input logic [1:0] sz,
                                               input logic [1:0] off);
        place_data = {32'h0000_0000, wdata & size_mask(sz)} << {off, 3'b000};
    endfunction

    function automatic logic [7:0] place_strb(input logic [1:0] sz, input logic [1:0] off);
        place_strb = {4'h0, strb_base(sz)} << off;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extend = {24'h00_0000, raw[7:0]};
            3'b101:  extend = {16'h0000, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    state_t            state_r;
    state_t            nxt_state_s;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [4:0]        rd_r;
    logic [31:0]       w0_r;

    logic              nxt_req_ready_s;
    logic              nxt_rsp_valid_s;
    logic [31:0]       nxt_rsp_rdata_s;
    logic [4:0]        nxt_rsp_rd_s;
    logic              nxt_rsp_err_s;
    logic              nxt_mem_en_s;
    logic [3:0]        nxt_mem_we_s;
    logic [ADDR_W-1:0] nxt_mem_addr_s;
    logic [31:0]       nxt_mem_wdata_s;

    logic              req_bad_s;
    logic [ADDR_W-1:0] req_word_s;
    logic [31:0]       req_lanes_s;
    logic [3:0]        req_strb_s;
    logic              lat_split_s;
    logic [ADDR_W-1:0] lat_word1_s;
    logic [31:0]       lat_lanes_s;
    logic [3:0]        lat_strb_s;
    logic [31:0]       load_win_s;

    assign req_bad_s   = !legal_op(req_we, req_funct3) ||
                         (!ALLOW_MISALIGNED && crosses(req_addr[1:0], req_funct3[1:0]));
    assign req_word_s  = {req_addr[ADDR_W-1:2], 2'b00};
    assign req_lanes_s = 32'(place_data(req_wdata, req_funct3[1:0], req_addr[1:0]));
    assign req_strb_s  = 4'(place_strb(req_funct3[1:0], req_addr[1:0]));

    assign lat_split_s = crosses(addr_r[1:0], funct3_r[1:0]);
    assign lat_word1_s = {addr_r[ADDR_W-1:2], 2'b00} + ADDR_W'(3'd4);
    assign lat_lanes_s = 32'(place_data(wdata_r, funct3_r[1:0], addr_r[1:0]) >> 32);
    assign lat_strb_s  = 4'(place_strb(funct3_r[1:0], addr_r[1:0]) >> 4);

    // In W1 the word on mem_rdata is the upper half of the {w1,w0} window.
    assign load_win_s  = 32'(((state_r == S_W1) ? {mem_rdata, w0_r} : {32'h0000_0000, mem_rdata})
                             >> {addr_r[1:0], 3'b000});

    // Next state and next value of every registered output.
    always_comb begin
        nxt_state_s     = state_r;
        nxt_rsp_valid_s = 1'b0;
        nxt_rsp_rdata_s = 32'h0000_0000;
        nxt_rsp_rd_s    = 5'd0;
        nxt_rsp_err_s   = 1'b0;
        nxt_mem_en_s    = 1'b0;
        nxt_mem_we_s    = 4'h0;
        nxt_mem_addr_s  = {ADDR_W{1'b0}};
        nxt_mem_wdata_s = 32'h0000_0000;
        case (state_r)
            S_IDLE: begin
                if (req_valid && req_bad_s) begin
                    nxt_state_s     = S_RSP;
                    nxt_rsp_valid_s = 1'b1;
                    nxt_rsp_err_s   = 1'b1;
                end else if (req_valid) begin
                    nxt_state_s    = S_A0;
                    nxt_mem_en_s   = 1'b1;
                    nxt_mem_addr_s = req_word_s;
                    if (req_we) begin
                        nxt_mem_we_s    = req_strb_s;
                        nxt_mem_wdata_s = req_lanes_s;
                    end else begin
                        nxt_mem_we_s    = 4'h0;
                        nxt_mem_wdata_s = 32'h0000_0000;
                    end
                end else begin
                    nxt_state_s = S_IDLE;
                end
            end
            S_A0: begin
                if (lat_split_s) begin
                    nxt_state_s    = S_A1;
                    nxt_mem_en_s   = 1'b1;
                    nxt_mem_addr_s = lat_word1_s;
                    if (we_r) begin
                        nxt_mem_we_s    = lat_strb_s;
                        nxt_mem_wdata_s = lat_lanes_s;
                    end else begin
                        nxt_mem_we_s    = 4'h0;
                        nxt_mem_wdata_s = 32'h0000_0000;
                    end
                end else if (we_r) begin
                    nxt_state_s     = S_RSP;
                    nxt_rsp_valid_s = 1'b1;
                end else begin
                    nxt_state_s = S_W0;
                end
            end
            S_A1: begin
                if (we_r) begin
                    nxt_state_s     = S_RSP;
                    nxt_rsp_valid_s = 1'b1;
                end else begin
                    nxt_state_s = S_W1;
                end
            end
            S_W0, S_W1: begin
                nxt_state_s     = S_RSP;
                nxt_rsp_valid_s = 1'b1;
                nxt_rsp_rdata_s = extend(load_win_s, funct3_r);
                nxt_rsp_rd_s    = rd_r;
            end
            S_RSP: begin
                nxt_state_s = S_IDLE;
            end
            default: begin
                nxt_state_s = S_IDLE;
            end
        endcase
        nxt_req_ready_s = (nxt_state_s == S_IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_rd    <= 5'd0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 4'h0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= 32'h0000_0000;
        end else begin
            state_r   <= nxt_state_s;
            req_ready <= nxt_req_ready_s;
            rsp_valid <= nxt_rsp_valid_s;
            rsp_rdata <= nxt_rsp_rdata_s;
            rsp_rd    <= nxt_rsp_rd_s;
            rsp_err   <= nxt_rsp_err_s;
            mem_en    <= nxt_mem_en_s;
            mem_we    <= nxt_mem_we_s;
            mem_addr  <= nxt_mem_addr_s;
            mem_wdata <= nxt_mem_wdata_s;
        end
    end

    // Request fields latched on accept; word 0 captured in A1 of a split load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= 32'h0000_0000;
            rd_r     <= 5'd0;
            w0_r     <= 32'h0000_0000;
        end else begin
            if (state_r == S_IDLE && req_valid) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
                rd_r     <= req_rd;
            end
            if (state_r == S_A1 && !we_r) begin
                w0_r <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_seq.sv
// Randomized scoreboard bench for lsu_mem_seq: a byte-level reference model predicts
// every memory access and response; a negedge monitor pops and compares.
module tb_lsu_mem_seq;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        req_ready, rsp_valid, rsp_err, mem_en;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [4:0]  rsp_rd;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata = 32'h0000_0000;

    logic        req_valid_b;
    logic        req_ready_b, rsp_valid_b, rsp_err_b, mem_en_b;
    logic [31:0] rsp_rdata_b, mem_addr_b, mem_wdata_b;
    logic [4:0]  rsp_rd_b;
    logic [3:0]  mem_we_b;

    logic [31:0] mem [16];
    logic [31:0] img [16];
    logic [7:0]  ref_mem [64];
    logic        load_mem = 1'b1;

    rsp_t rspq[$];
    rsp_t rspq_b[$];
    acc_t accq[$];

    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   tmo = 0, tmo_seen = 0;
    bit   end_req = 1'b0, end_done = 1'b0;
    rsp_t mr;
    acc_t ma;

    always #5 clk = ~clk;

    lsu_mem_seq #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Strict-alignment instance sees only requests the main instance accepts.
    assign req_valid_b = req_valid & req_ready;

    lsu_mem_seq #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_rd(rsp_rd_b), .rsp_err(rsp_err_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous data memory: 16 words, read data valid the cycle after the read.
    always @(posedge clk) begin
        if (load_mem) begin
            mem <= img;
        end else if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= mem[mem_addr[5:2]];
            end else begin
                for (int l = 0; l < 4; l++)
                    if (mem_we[l]) mem[mem_addr[5:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
            end
        end
    end

    // Reference model: byte-level view of the operation, pushed at accept time.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int acc);
        int n;
        bit split, legal;
        logic [31:0] w0a, w1a, b, val, d0, d1;
        logic [3:0] s0, s1;
        rsp_t r, e;
        acc_t a;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        split = (int'(addr[1:0]) + n) > 4;
        w0a = addr & 32'hFFFF_FFFC;
        w1a = w0a + 32'd4;
        e.rdata = 32'h0; e.rd = 5'd0; e.err = 1'b1; e.cyc = acc;
        r.rdata = 32'h0; r.rd = 5'd0; r.err = 1'b0; r.cyc = acc;
        if (!legal) begin
            rspq.push_back(e);
            rspq_b.push_back(e);
        end else begin
            if (we) begin
                s0 = 4'h0; s1 = 4'h0; d0 = 32'h0; d1 = 32'h0;
                for (int i = 0; i < n; i++) begin
                    b = addr + 32'(i);
                    ref_mem[b[5:0]] = wdata[8*i +: 8];
                    if ((b & 32'hFFFF_FFFC) == w0a) begin
                        s0[b[1:0]] = 1'b1; d0[8*b[1:0] +: 8] = wdata[8*i +: 8];
                    end else begin
                        s1[b[1:0]] = 1'b1; d1[8*b[1:0] +: 8] = wdata[8*i +: 8];
                    end
                end
                a.addr = w0a; a.we = s0; a.wdata = d0; accq.push_back(a);
                if (split) begin a.addr = w1a; a.we = s1; a.wdata = d1; accq.push_back(a); end
                r.cyc = acc + (split ? 2 : 1);
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++) begin
                    b = addr + 32'(i);
                    val[8*i +: 8] = ref_mem[b[5:0]];
                end
                if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
                if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
                a.addr = w0a; a.we = 4'h0; a.wdata = 32'h0; accq.push_back(a);
                if (split) begin a.addr = w1a; accq.push_back(a); end
                r.rdata = val; r.rd = rd; r.cyc = acc + (split ? 3 : 2);
            end
            rspq.push_back(r);
            rspq_b.push_back(split ? e : r);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (mem_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_we !== 4'h0 ||
                rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || mem_en_b !== 1'b0 || rsp_valid_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_state mem_en=%b req_ready=%b rsp_valid=%b mem_we=%b rdata=%h err=%b b_en=%b b_rsp=%b want 0 1 0 0000 0 0 0 0",
                         mem_en, req_ready, rsp_valid, mem_we, rsp_rdata, rsp_err, mem_en_b, rsp_valid_b);
            end
            accq.delete(); rspq.delete(); rspq_b.delete();
        end else begin
            if (mem_en) begin
                checks++;
                if (accq.size() == 0) begin
                    errors++;
                    $display("FAIL mem_access unexpected addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata);
                end else begin
                    ma = accq.pop_front();
                    if (mem_addr !== ma.addr || mem_we !== ma.we || mem_wdata !== ma.wdata) begin
                        errors++;
                        $display("FAIL mem_access got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                                 mem_addr, mem_we, mem_wdata, ma.addr, ma.we, ma.wdata);
                    end
                end
            end
            if (rsp_valid) begin
                checks++;
                if (rspq.size() == 0) begin
                    errors++;
                    $display("FAIL rsp unexpected rdata=%h rd=%0d err=%b", rsp_rdata, rsp_rd, rsp_err);
                end else begin
                    mr = rspq.pop_front();
                    if (rsp_rdata !== mr.rdata || rsp_rd !== mr.rd || rsp_err !== mr.err || cyc != mr.cyc) begin
                        errors++;
                        $display("FAIL rsp got rdata=%h rd=%0d err=%b cyc=%0d want rdata=%h rd=%0d err=%b cyc=%0d",
                                 rsp_rdata, rsp_rd, rsp_err, cyc, mr.rdata, mr.rd, mr.err, mr.cyc);
                    end
                end
            end
            if (mem_en_b) begin
                checks++;
                if (!mem_en || mem_addr_b !== mem_addr || mem_we_b !== mem_we || mem_wdata_b !== mem_wdata) begin
                    errors++;
                    $display("FAIL strict_access got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h en=%b",
                             mem_addr_b, mem_we_b, mem_wdata_b, mem_addr, mem_we, mem_wdata, mem_en);
                end
            end
            if (rsp_valid_b) begin
                checks++;
                if (rspq_b.size() == 0) begin
                    errors++;
                    $display("FAIL strict_rsp unexpected rdata=%h err=%b", rsp_rdata_b, rsp_err_b);
                end else begin
                    mr = rspq_b.pop_front();
                    if (rsp_rdata_b !== mr.rdata || rsp_rd_b !== mr.rd || rsp_err_b !== mr.err || cyc != mr.cyc) begin
                        errors++;
                        $display("FAIL strict_rsp got rdata=%h rd=%0d err=%b cyc=%0d want rdata=%h rd=%0d err=%b cyc=%0d",
                                 rsp_rdata_b, rsp_rd_b, rsp_err_b, cyc, mr.rdata, mr.rd, mr.err, mr.cyc);
                    end
                end
            end
        end
        if (tmo != tmo_seen) begin
            checks++;
            errors++;
            $display("FAIL wait_ready timeout count=%0d want 0", tmo);
            tmo_seen = tmo;
        end
        if (end_req && !end_done) begin
            checks++;
            if (accq.size() != 0 || rspq.size() != 0 || rspq_b.size() != 0) begin
                errors++;
                $display("FAIL drain pending acc=%0d rsp=%0d strict=%0d want 0 0 0",
                         accq.size(), rspq.size(), rspq_b.size());
            end
            end_done = 1'b1;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_rd     = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) tmo++;
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        wait_ready();
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk); #1;
        model(we, f3, addr, wdata, rd, cyc);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] lf3 [5];
        bit we;
        logic [2:0] f3;
        int n;
        lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        img[0] = 32'h6F40_9348;
        img[1] = 32'hAABB_CCDD;
        for (int k = 2; k < 16; k++) img[k] = $urandom;
        for (int k = 0; k < 64; k++) ref_mem[k] = img[k/4][8*(k%4) +: 8];
        repeat (3) @(posedge clk);
        #1;
        load_mem = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 3'b101, 32'h0000_0000, 32'h0, 5'd3);    // LHU @0
        issue(1'b0, 3'b001, 32'h0000_0000, 32'h0, 5'd4);    // LH @0
        issue(1'b0, 3'b001, 32'h0000_0002, 32'h0, 5'd5);    // LH @2
        issue(1'b0, 3'b000, 32'h0000_0001, 32'h0, 5'd6);    // LB @1
        issue(1'b0, 3'b100, 32'h0000_0001, 32'h0, 5'd7);    // LBU @1
        issue(1'b0, 3'b010, 32'h0000_0001, 32'h0, 5'd8);    // LW @1, split
        issue(1'b0, 3'b101, 32'h0000_0003, 32'h0, 5'd9);    // LHU @3, split
        issue(1'b1, 3'b001, 32'h0000_0003, 32'h0000_1234, 5'd10);  // SH @3, split
        issue(1'b1, 3'b000, 32'h0000_0002, 32'hFFFF_FFA5, 5'd11);  // SB @2
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd12);   // illegal load
        issue(1'b1, 3'b100, 32'h0000_0004, 32'h1, 5'd13);   // illegal store
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 5'd14);   // split load wrapping to 0
        issue(1'b1, 3'b010, 32'hFFFF_FFFD, 32'hCAFE_F00D, 5'd15);  // split store wrapping

        // Abandon a split load while it is in A1.
        issue(1'b0, 3'b010, 32'h0000_0001, 32'h0, 5'd16);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 3'b101, 32'h0000_0000, 32'h0, 5'd17);

        for (int t = 0; t < 300; t++) begin
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = lf3[$urandom_range(0, 4)];
            issue(we, f3, $urandom, $urandom, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        wait_ready();
        req_valid = 1'b0;
        end_req = 1'b1;
        n = 0;
        while (!end_done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
